// File: rtl/adder_share_ctrl_if.sv
// Requester, response and shared-adder signals of adder_share_ctrl.
// The controller takes the slave view. It serves the requesters and the
// response consumer, and it also drives the shared adder's operands.
// The master view belongs to whatever surrounds the controller:
// the requesters, the consumer and the adder itself.
interface adder_share_ctrl_if #(
  parameter int HALF_W = 5
);
  logic                  req0_valid;
  logic [2*HALF_W-1:0]   req0_a;
  logic [2*HALF_W-1:0]   req0_b;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [2*HALF_W-1:0]   req1_a;
  logic [2*HALF_W-1:0]   req1_b;
  logic                  req1_ready;
  logic [HALF_W-1:0]     add_x;
  logic [HALF_W-1:0]     add_y;
  logic [HALF_W-1:0]     add_s;
  logic                  add_c5;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_id;
  logic [2*HALF_W-1:0]   resp_sum;
  logic                  resp_cout;
  logic                  busy;
  logic [7:0]            op_count;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  add_s, add_c5, resp_ready,
    output req0_ready, req1_ready, add_x, add_y,
    output resp_valid, resp_id, resp_sum, resp_cout, busy, op_count
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output add_s, add_c5, resp_ready,
    input  req0_ready, req1_ready, add_x, add_y,
    input  resp_valid, resp_id, resp_sum, resp_cout, busy, op_count
  );
endinterface

// File: rtl/adder_share_ctrl.sv
// Shares one HALF_W-bit adder between two requesters to produce
// 2*HALF_W-bit sums. Requesters are served round-robin.
// Each add runs as a low pass and then a high pass. When the low pass
// carries, an extra pass adds 1 into the upper half.
// The result leaves on a valid/ready channel tagged with the requester id.
module adder_share_ctrl #(
  parameter int HALF_W  = 5,
  parameter bit RR_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_share_ctrl_if.slave bus
);
  localparam int W = 2 * HALF_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_INC  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_id;
  logic            r_c_lo;
  logic            r_c_hi;
  logic            r_last_grant;
  logic [7:0]      r_op_count;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_cap;

  // Round-robin grant, offered only while idle; contention goes to the requester not served last
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_gnt0 = r_last_grant;
        w_gnt1 = ~r_last_grant;
      end else begin
        w_gnt0 = bus.req0_valid;
        w_gnt1 = bus.req1_valid;
      end
    end
  end

  assign w_cap          = w_gnt0 | w_gnt1;
  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: the increment pass runs only when the low half carried
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cap) w_next = S_LO;
      S_LO:    w_next = S_HI;
      S_HI:    w_next = r_c_lo ? S_INC : S_RESP;
      S_INC:   w_next = S_RESP;
      S_RESP:  if (bus.resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Shared-adder operands for the current pass; zero when no pass is running
  always_comb begin
    bus.add_x = '0;
    bus.add_y = '0;
    case (r_state)
      S_LO: begin
        bus.add_x = r_a[HALF_W-1:0];
        bus.add_y = r_b[HALF_W-1:0];
      end
      S_HI: begin
        bus.add_x = r_a[W-1:HALF_W];
        bus.add_y = r_b[W-1:HALF_W];
      end
      S_INC: begin
        bus.add_x = r_sum[W-1:HALF_W];
        bus.add_y = {{(HALF_W-1){1'b0}}, 1'b1};
      end
      default: ;
    endcase
  end

  // Operand capture, per-pass result collection and completion count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_id         <= 1'b0;
      r_c_lo       <= 1'b0;
      r_c_hi       <= 1'b0;
      r_last_grant <= RR_INIT;
      r_op_count   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cap) begin
            r_a          <= w_gnt1 ? bus.req1_a : bus.req0_a;
            r_b          <= w_gnt1 ? bus.req1_b : bus.req0_b;
            r_id         <= w_gnt1;
            r_last_grant <= w_gnt1;
          end
        end
        S_LO: begin
          r_sum[HALF_W-1:0] <= bus.add_s;
          r_c_lo            <= bus.add_c5;
        end
        S_HI: begin
          r_sum[W-1:HALF_W] <= bus.add_s;
          r_c_hi            <= bus.add_c5;
        end
        S_INC: begin
          // The high pass and the increment cannot both carry; OR keeps either
          r_sum[W-1:HALF_W] <= bus.add_s;
          r_c_hi            <= r_c_hi | bus.add_c5;
        end
        S_RESP: begin
          if (bus.resp_ready) r_op_count <= r_op_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_id    = r_id;
  assign bus.resp_sum   = r_sum;
  assign bus.resp_cout  = r_c_hi;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.op_count   = r_op_count;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: shared adder model, transaction-level
// reference model with per-cycle compare, and directed scenarios.
module tb_adder_share_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  adder_share_ctrl_if #(.HALF_W(5)) bus ();

  adder_share_ctrl #(.HALF_W(5), .RR_INIT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The shared 5-bit adder, carry-in tied to 0
  assign {bus.add_c5, bus.add_s} = {1'b0, bus.add_x} + {1'b0, bus.add_y};

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] f_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  logic       m_busy = 1'b0;
  int         m_k    = 0;     // cycles since capture (1 = low pass)
  int         m_lat  = 2;     // capture-to-response cycles
  logic [9:0] m_a    = '0;
  logic [9:0] m_b    = '0;
  logic       m_id   = 1'b0;
  logic       m_last = 1'b1;
  logic [7:0] m_cnt  = '0;

  wire [1:0]  w_mg  = f_grant(bus.req0_valid, bus.req1_valid, m_last);
  wire [9:0]  w_ca  = w_mg[1] ? bus.req1_a : bus.req0_a;
  wire [9:0]  w_cb  = w_mg[1] ? bus.req1_b : bus.req0_b;
  wire [5:0]  w_clo = {1'b0, w_ca[4:0]} + {1'b0, w_cb[4:0]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_k <= 0; m_lat <= 2; m_a <= '0; m_b <= '0;
      m_id <= 1'b0; m_last <= 1'b1; m_cnt <= '0;
    end else if (!m_busy) begin
      if (w_mg != 2'b00) begin
        m_busy <= 1'b1; m_k <= 1; m_a <= w_ca; m_b <= w_cb;
        m_id <= w_mg[1]; m_last <= w_mg[1];
        m_lat <= w_clo[5] ? 3 : 2;
      end
    end else if (m_k > m_lat && bus.resp_ready) begin
      m_busy <= 1'b0;
      m_cnt  <= m_cnt + 8'd1;
    end else begin
      m_k <= m_k + 1;
    end
  end

  wire [5:0]  w_hs   = {1'b0, m_a[9:5]} + {1'b0, m_b[9:5]};
  wire [10:0] w_tot  = {1'b0, m_a} + {1'b0, m_b};
  wire        e_inc  = m_busy && m_k == 3 && m_lat == 3;
  wire [4:0]  e_x    = !m_busy ? 5'd0 : (m_k == 1) ? m_a[4:0] : (m_k == 2) ? m_a[9:5] :
                       e_inc ? w_hs[4:0] : 5'd0;
  wire [4:0]  e_y    = !m_busy ? 5'd0 : (m_k == 1) ? m_b[4:0] : (m_k == 2) ? m_b[9:5] :
                       e_inc ? 5'd1 : 5'd0;
  wire        e_resp = m_busy && (m_k > m_lat);
  wire [1:0]  e_rdy  = m_busy ? 2'b00 : w_mg;

  always @(negedge clk) begin
    chk("busy",       int'(bus.busy),       int'(m_busy));
    chk("resp_valid", int'(bus.resp_valid), int'(e_resp));
    chk("add_x",      int'(bus.add_x),      int'(e_x));
    chk("add_y",      int'(bus.add_y),      int'(e_y));
    chk("req0_ready", int'(bus.req0_ready), int'(e_rdy[0]));
    chk("req1_ready", int'(bus.req1_ready), int'(e_rdy[1]));
    chk("op_count",   int'(bus.op_count),   int'(m_cnt));
    if (e_resp) begin
      chk("resp_sum",  int'(bus.resp_sum),  int'(w_tot[9:0]));
      chk("resp_cout", int'(bus.resp_cout), int'(w_tot[10]));
      chk("resp_id",   int'(bus.resp_id),   int'(m_id));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [4:0] xs [4];
  logic [4:0] ys [4];
  int         o_lat;
  logic [9:0] o_sum;
  logic       o_cout;
  logic       o_id;

  task automatic set_req(input logic id, input logic v, input logic [9:0] a, input logic [9:0] b);
    if (id) begin bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; end
    else    begin bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; end
  endtask

  task automatic do_op(input logic id, input logic [9:0] a, input logic [9:0] b);
    bit got;
    @(posedge clk); #1;
    set_req(id, 1'b1, a, b);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) got = 1;
    end
    if (!got) chk("req_ready_timeout", 0, 1);
    @(posedge clk); #1;
    set_req(id, 1'b0, a, b);
    for (int i = 0; i < 4; i++) begin xs[i] = '0; ys[i] = '0; end
    o_lat = 0;
    got   = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (i < 4) begin xs[i] = bus.add_x; ys[i] = bus.add_y; end
      if (bus.resp_valid) got = 1;
      else o_lat++;
    end
    if (!got) chk("resp_timeout", 0, 1);
    o_sum  = bus.resp_sum;
    o_cout = bus.resp_cout;
    o_id   = bus.resp_id;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int   gn;
  int   rn;
  logic gseq [4];
  logic rseq [4];
  bit   done;

  initial begin
    set_req(1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0);
    bus.resp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_busy",       int'(bus.busy),       0);
    chk("rst_op_count",   int'(bus.op_count),   0);
    chk("rst_resp_sum",   int'(bus.resp_sum),   0);
    chk("rst_add_x",      int'(bus.add_x),      0);
    rst_n = 1'b1;

    // Single op, no low carry
    do_op(1'b0, 10'd100, 10'd200);
    chk("t1_lat", o_lat, 2);
    chk("t1_lo_x", int'(xs[0]), 4);  chk("t1_lo_y", int'(ys[0]), 8);
    chk("t1_hi_x", int'(xs[1]), 3);  chk("t1_hi_y", int'(ys[1]), 6);
    chk("t1_noinc_y", int'(ys[2]), 0);
    chk("t1_sum", int'(o_sum), 300); chk("t1_cout", int'(o_cout), 0); chk("t1_id", int'(o_id), 0);
    @(negedge clk);
    chk("t1_op_count", int'(bus.op_count), 1);

    // Low carry forces the increment pass
    do_op(1'b1, 10'd31, 10'd1);
    chk("t2_lat", o_lat, 3);
    chk("t2_lo_x", int'(xs[0]), 31); chk("t2_lo_y", int'(ys[0]), 1);
    chk("t2_inc_x", int'(xs[2]), 0); chk("t2_inc_y", int'(ys[2]), 1);
    chk("t2_sum", int'(o_sum), 32);  chk("t2_cout", int'(o_cout), 0); chk("t2_id", int'(o_id), 1);

    // Full overflow through the increment, and through the high pass alone
    do_op(1'b0, 10'd1023, 10'd1);
    chk("t3_inc_x", int'(xs[2]), 31);
    chk("t3_sum", int'(o_sum), 0);   chk("t3_cout", int'(o_cout), 1);
    do_op(1'b1, 10'd512, 10'd512);
    chk("t3b_lat", o_lat, 2);
    chk("t3b_sum", int'(o_sum), 0);  chk("t3b_cout", int'(o_cout), 1);

    // Contention from reset: both requesters always valid
    pulse_reset();
    set_req(1'b0, 1'b1, 10'd10, 10'd20);
    set_req(1'b1, 1'b1, 10'd300, 10'd400);
    gn = 0; rn = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (bus.req0_ready && gn < 4) begin gseq[gn] = 1'b0; gn++; end
      if (bus.req1_ready && gn < 4) begin gseq[gn] = 1'b1; gn++; end
      if (bus.resp_valid && bus.resp_ready && rn < 4) begin rseq[rn] = bus.resp_id; rn++; end
      if (rn >= 4) done = 1;
    end
    chk("rr_count", rn, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant", int'(gseq[i]), i % 2);
      chk("rr_resp_id", int'(rseq[i]), i % 2);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1;
    end
    chk("rr_drain", int'(done), 1);

    // Back-pressure: response held for 5 cycles with a request waiting
    bus.resp_ready = 1'b0;
    do_op(1'b0, 10'd700, 10'd300);
    set_req(1'b1, 1'b1, 10'd1, 10'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(bus.resp_valid), 1);
      chk("bp_sum",   int'(bus.resp_sum),   1000);
      chk("bp_busy",  int'(bus.busy),       1);
      chk("bp_rdy1",  int'(bus.req1_ready), 0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    set_req(1'b1, 1'b0, '0, '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_busy",  int'(bus.busy),       0);
    chk("bp_idle_valid", int'(bus.resp_valid), 0);

    // Async reset during the increment pass
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 10'd31, 10'd1);
    @(posedge clk); #1;             // captured at this edge
    set_req(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("inc_y_before_rst", int'(bus.add_y), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(bus.resp_valid), 0);
    chk("arst_busy",  int'(bus.busy),       0);
    chk("arst_x",     int'(bus.add_x),      0);
    chk("arst_y",     int'(bus.add_y),      0);
    chk("arst_cnt",   int'(bus.op_count),   0);
    chk("arst_sum",   int'(bus.resp_sum),   0);
    chk("arst_cout",  int'(bus.resp_cout),  0);
    chk("arst_id",    int'(bus.resp_id),    0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("arst_no_resp", int'(bus.resp_valid), 0);
    end

    // 256 completions wrap op_count to 0
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 10'd5, 10'd7);
    rn = 0; done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (bus.resp_valid && bus.resp_ready) begin
        rn++;
        if (rn == 256) begin
          chk("wrap_pre", int'(bus.op_count), 255);
          done = 1;
        end
      end
    end
    chk("wrap_count", rn, 256);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("wrap_zero", int'(bus.op_count), 0);
    chk("wrap_idle", int'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
